// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
package mem_stage_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding RAM request; flags the last allowed cycle.
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    // High on the final wait cycle; the controller gives up at the following edge.
    assign expired_c = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: stalls the pipeline while a load/store waits for the data RAM.
// Optional misaligned-access trap enabled by defining MEM_STAGE_ALIGN_CHECK_EN.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic [WORD_W-1:0] ALUResult,
    input  logic [WORD_W-1:0] WriteData,
    input  logic              MemAck,
    input  logic [WORD_W-1:0] MemRData,
    output logic              MemReq,
    output logic              MemWe,
    output logic [WORD_W-1:0] MemAddr,
    output logic [WORD_W-1:0] MemWData,
    output logic [WORD_W-1:0] ReadData,
    output logic              RegWrite_Out,
    output logic              Stall,
    output logic              BusErr,
    output logic              AlignErr
);

    memState_e         state, stateNext;
    logic              memReqNext, memWeNext, busErrNext;
    logic [WORD_W-1:0] memAddrNext, memWDataNext, readDataNext;
    logic              ctrClear, ctrInc, expired;
    logic              access, misaligned;
    logic [WORD_W-1:0] alignedAddr;

    assign access = MemRead || MemWrite;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misaligned  = (ALUResult[1:0] != 2'b00);
    assign alignedAddr = ALUResult;

    // Misaligned access is dropped in IDLE and reported one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            AlignErr <= 1'b0;
        end else begin
            AlignErr <= (state == IDLE) && access && misaligned;
        end
    end
`else
    logic unusedAddrLsb;

    assign misaligned    = 1'b0;
    assign alignedAddr   = {ALUResult[WORD_W-1:2], 2'b00};
    assign AlignErr      = 1'b0;
    assign unusedAddrLsb = ^ALUResult[1:0];
`endif

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeoutCtr (
        .clk       (clk),
        .reset     (reset),
        .clear     (ctrClear),
        .inc       (ctrInc),
        .expired_c (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            ReadData <= '0;
            BusErr   <= 1'b0;
        end else begin
            state    <= stateNext;
            MemReq   <= memReqNext;
            MemWe    <= memWeNext;
            MemAddr  <= memAddrNext;
            MemWData <= memWDataNext;
            ReadData <= readDataNext;
            BusErr   <= busErrNext;
        end
    end

    // Next-state, registered-output next values and combinational pipeline controls.
    always_comb begin
        stateNext    = state;
        memReqNext   = MemReq;
        memWeNext    = MemWe;
        memAddrNext  = MemAddr;
        memWDataNext = MemWData;
        readDataNext = ReadData;
        busErrNext   = 1'b0;
        Stall        = 1'b0;
        RegWrite_Out = 1'b0;
        ctrClear     = 1'b0;
        ctrInc       = 1'b0;

        case (state)
            IDLE: begin
                ctrClear = 1'b1;
                if (access && !misaligned) begin
                    Stall        = 1'b1;
                    stateNext    = WAIT;
                    memReqNext   = 1'b1;
                    memWeNext    = MemWrite;
                    memAddrNext  = alignedAddr;
                    memWDataNext = WriteData;
                end else if (!access) begin
                    RegWrite_Out = RegWrite;
                end
            end
            WAIT: begin
                Stall  = 1'b1;
                ctrInc = 1'b1;
                // An ack on the last allowed cycle still completes the access.
                if (MemAck) begin
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    stateNext  = DONE;
                    if (!MemWe) begin
                        readDataNext = MemRData;
                    end
                end else if (expired) begin
                    memReqNext   = 1'b0;
                    memWeNext    = 1'b0;
                    readDataNext = '0;
                    busErrNext   = 1'b1;
                    stateNext    = DONE;
                end
            end
            DONE: begin
                RegWrite_Out = RegWrite;
                stateNext    = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: table-driven accesses with a scoreboard,
// plus hand sequences for idle acks, mid-access reset and the optional alignment trap.
module tb_mem_stage_ctrl;

    localparam int unsigned TO     = 16;
    localparam int          BUDGET = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, RegWrite, MemAck;
    logic [31:0] ALUResult, WriteData, MemRData;
    logic        MemReq, MemWe, RegWrite_Out, Stall, BusErr, AlignErr;
    logic [31:0] MemAddr, MemWData, ReadData;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .MemAck       (MemAck),
        .MemRData     (MemRData),
        .MemReq       (MemReq),
        .MemWe        (MemWe),
        .MemAddr      (MemAddr),
        .MemWData     (MemWData),
        .ReadData     (ReadData),
        .RegWrite_Out (RegWrite_Out),
        .Stall        (Stall),
        .BusErr       (BusErr),
        .AlignErr     (AlignErr)
    );

    typedef struct {
        logic        rd, wr, rw;
        logic [31:0] addr, wdata;
        int          ackAt;        // ack on this WAIT cycle (1-based), 0 = never
        logic [31:0] rdata;
        int          expStall, expReq;
        logic        expWe;
        logic [31:0] expAddr, expRd;
        logic        expBe;
    } vec_t;

    typedef struct {
        int          stall, req;
        logic [31:0] rd;
        logic        be, rw;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   nPass  = 0;
    int   nTotal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nTotal++;
        if (act === want) nPass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, want, $time);
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic rw,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int ackAt, input logic [31:0] rdata,
                                input int expStall, input int expReq, input logic expWe,
                                input logic [31:0] expAddr, input logic [31:0] expRd,
                                input logic expBe);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.addr = addr; v.wdata = wdata;
        v.ackAt = ackAt; v.rdata = rdata; v.expStall = expStall; v.expReq = expReq;
        v.expWe = expWe; v.expAddr = expAddr; v.expRd = expRd; v.expBe = expBe;
        return v;
    endfunction

    // Drives one MEM-stage instruction until the pipeline is released, acking as scheduled.
    task automatic doAccess(input vec_t v);
        int   stallCnt = 0;
        int   reqCnt   = 0;
        int   waitCnt  = 0;
        logic done     = 1'b0;
        exp_t e;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                MemRead   = v.rd;
                MemWrite  = v.wr;
                RegWrite  = v.rw;
                ALUResult = v.addr;
                WriteData = v.wdata;
                sb.push_back('{stall: v.expStall, req: v.expReq, rd: v.expRd, be: v.expBe, rw: v.rw});
            end
            if (MemReq) waitCnt++;
            MemAck   = MemReq && (waitCnt == v.ackAt);
            MemRData = MemAck ? v.rdata : 32'h5A5A_5A5A;
            @(negedge clk);
            check("alignErrQuiet", 32'(AlignErr), 32'd0);
            if (Stall) begin
                stallCnt++;
                check("regWrGated", 32'(RegWrite_Out), 32'd0);
                check("busErrQuiet", 32'(BusErr), 32'd0);
                if (MemReq) begin
                    reqCnt++;
                    check("memWe", 32'(MemWe), 32'(v.expWe));
                    check("memAddr", MemAddr, v.expAddr);
                    check("memWData", MemWData, v.wdata);
                end
            end else begin
                e = sb.pop_front();
                check("stallCycles", 32'(stallCnt), 32'(e.stall));
                check("reqCycles", 32'(reqCnt), 32'(e.req));
                check("readData", ReadData, e.rd);
                check("busErr", 32'(BusErr), 32'(e.be));
                check("regWrOut", 32'(RegWrite_Out), 32'(e.rw));
                check("reqDropped", 32'(MemReq), 32'd0);
                done = 1'b1;
            end
        end
        check("releasedInBudget", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] holdRd;

        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0; MemAck = 1'b0;
        ALUResult = '0; WriteData = '0; MemRData = '0;

        //   rd wr rw addr        wdata        ack rdata         stl req we  expAddr expRd        be
        tbl.push_back(mk(0, 0, 1, 32'h100, 32'h0,        0,  32'h0,        0,  0,  0, 32'h0,  32'h0,        0));
        tbl.push_back(mk(1, 0, 1, 32'h10,  32'h0,        2,  32'hDEADBEEF, 3,  2,  0, 32'h10, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 0, 1, 32'h104, 32'h0,        0,  32'h0,        0,  0,  0, 32'h0,  32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 1, 0, 32'h20,  32'h12345678, 1,  32'h99999999, 2,  1,  1, 32'h20, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 0, 1, 32'h44,  32'h0,        5,  32'hCAFEF00D, 6,  5,  0, 32'h44, 32'hCAFEF00D, 0));
        tbl.push_back(mk(1, 1, 0, 32'h30,  32'hA5A5A5A5, 1,  32'h11111111, 2,  1,  1, 32'h30, 32'hCAFEF00D, 0));
        tbl.push_back(mk(1, 0, 1, 32'h50,  32'h0,        0,  32'h0,        17, 16, 0, 32'h50, 32'h0,        1));
        tbl.push_back(mk(0, 0, 0, 32'h108, 32'h0,        0,  32'h0,        0,  0,  0, 32'h0,  32'h0,        0));
        tbl.push_back(mk(1, 0, 1, 32'h64,  32'h0,        16, 32'h600DCAFE, 17, 16, 0, 32'h64, 32'h600DCAFE, 0));
        tbl.push_back(mk(1, 0, 1, 32'h70,  32'h0,        1,  32'h13572468, 2,  1,  0, 32'h70, 32'h13572468, 0));
`ifndef MEM_STAGE_ALIGN_CHECK_EN
        tbl.push_back(mk(1, 0, 1, 32'h17,  32'h0,        1,  32'h0BADF00D, 2,  1,  0, 32'h14, 32'h0BADF00D, 0));
`endif
        holdRd = tbl[tbl.size() - 1].expRd;

        // Reset state
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rstMemReq", 32'(MemReq), 32'd0);
        check("rstMemWe", 32'(MemWe), 32'd0);
        check("rstMemAddr", MemAddr, 32'd0);
        check("rstMemWData", MemWData, 32'd0);
        check("rstReadData", ReadData, 32'd0);
        check("rstBusErr", 32'(BusErr), 32'd0);
        check("rstAlignErr", 32'(AlignErr), 32'd0);
        check("rstStall", 32'(Stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) doAccess(tbl[i]);

        // Ack while idle must not disturb anything
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b1; MemAck = 1'b1; MemRData = 32'hFFFF0000;
        @(negedge clk);
        check("idleAckNoReq", 32'(MemReq), 32'd0);
        check("idleAckNoStall", 32'(Stall), 32'd0);
        check("idleAluRegWr", 32'(RegWrite_Out), 32'd1);
        @(posedge clk); #1;
        MemAck = 1'b0;
        @(negedge clk);
        check("idleAckHoldRd", ReadData, holdRd);
        check("idleAckStillIdle", 32'(MemReq), 32'd0);

        // Reset on the third WAIT cycle, with an ack arriving in the same cycle and after
        @(posedge clk); #1;
        MemRead = 1'b1; RegWrite = 1'b1; ALUResult = 32'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstSeqInWait", 32'(MemReq), 32'd1);
        reset = 1'b1; MemAck = 1'b1; MemRData = 32'h77777777;
        @(posedge clk); #1;
        reset = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        check("midRstMemReq", 32'(MemReq), 32'd0);
        check("midRstStall", 32'(Stall), 32'd0);
        check("midRstReadData", ReadData, 32'd0);
        check("midRstBusErr", 32'(BusErr), 32'd0);
        check("midRstMemAddr", MemAddr, 32'd0);
        @(posedge clk); #1;
        MemAck = 1'b0;
        @(negedge clk);
        check("lateAckReadData", ReadData, 32'd0);
        check("lateAckMemReq", 32'(MemReq), 32'd0);
        check("lateAckStall", 32'(Stall), 32'd0);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
        // Misaligned load is trapped instead of issued
        @(posedge clk); #1;
        MemRead = 1'b1; RegWrite = 1'b1; ALUResult = 32'h13;
        @(negedge clk);
        check("misStall", 32'(Stall), 32'd0);
        check("misRegWr", 32'(RegWrite_Out), 32'd0);
        check("misNoReq", 32'(MemReq), 32'd0);
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(negedge clk);
        check("misAlignErr", 32'(AlignErr), 32'd1);
        check("misNoReqLater", 32'(MemReq), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("misAlignErrPulse", 32'(AlignErr), 32'd0);
`endif

        check("scoreboardEmpty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, gives the maximum cycles waited for MemAck before BusErr is raised (range 2..255).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 MemRead  in  1  load in the MEM stage (from EX_MEM).
REQ-005 MemWrite  in  1  store in the MEM stage (from EX_MEM).
REQ-006 RegWrite  in  1  register-write control of the MEM-stage instruction.
REQ-007 ALUResult  in  32  byte address of the access.
REQ-008 WriteData  in  32  store data.
REQ-009 MemAck  in  1  one-cycle completion strobe from data RAM.
REQ-010 MemRData  in  32  RAM read data, valid while MemAck=1.
REQ-011 MemReq  out  1  request to RAM, held until ack or timeout.
REQ-012 MemWe  out  1  request is a write.
REQ-013 MemAddr  out  32  registered access address.
REQ-014 MemWData  out  32  registered store data.
REQ-015 ReadData  out  32  load result for MEM_WB.
REQ-016 RegWrite_Out  out  1  RegWrite gated for MEM_WB.
REQ-017 Stall  out  1  freezes PC, IF_ID, ID_EX and EX_MEM.
REQ-018 BusErr  out  1  one-cycle pulse on access timeout.
REQ-019 AlignErr  out  1  one-cycle pulse on misaligned access (see Configuration).

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT and DONE.
REQ-021 IDLE, no access (MemRead=MemWrite=0): Stall=0; RegWrite_Out=RegWrite; no request; zero added latency.
REQ-022 IDLE, access present: Stall=1 combinationally; at the next edge MemReq=1, MemWe=MemWrite, MemAddr/MemWData are latched, state goes to WAIT, and the counter is cleared.
REQ-023 MemRead=MemWrite=1 SHALL be treated as a write.
REQ-024 WAIT: Stall=1; MemReq, MemWe, MemAddr and MemWData stay stable; the counter increments each cycle.
REQ-025 WAIT with MemAck=1: MemReq drops at the next edge; for a read, ReadData<=MemRData; the state goes to DONE.
REQ-026 WAIT with no ack and counter=TIMEOUT-1: MemReq drops; ReadData<=0; BusErr pulses for 1 cycle; the state goes to DONE.
REQ-027 DONE: Stall=0 for exactly one cycle so the instruction advances; RegWrite_Out=RegWrite; the next state is IDLE unconditionally.
REQ-028 RegWrite_Out SHALL be 0 whenever Stall=1.
REQ-029 MemAck in IDLE or DONE SHALL be ignored.
REQ-030 Minimum access latency SHALL be 3 cycles (detect, ack, DONE).
REQ-031 ReadData SHALL hold its value until the next load completes.

Reset
REQ-032 Reset SHALL force state=IDLE, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, ReadData=0, counter=0, BusErr=0 and AlignErr=0 at the next edge, including in the middle of an access in WAIT.
REQ-033 Reset SHALL take priority over MemAck and the timeout.

Configuration
REQ-034 Macro MEM_STAGE_ALIGN_CHECK_EN.
REQ-035 With MEM_STAGE_ALIGN_CHECK_EN defined: an access in IDLE with ALUResult[1:0]!=0 issues no request and stays in IDLE; Stall=0 and RegWrite_Out=0 that cycle; AlignErr pulses on the next cycle.
REQ-036 Without MEM_STAGE_ALIGN_CHECK_EN: AlignErr is tied to 0, and MemAddr[1:0] is forced to 0.

Structure
REQ-037 Package mem_stage_pkg SHALL hold the state enum (IDLE/WAIT/DONE), the TIMEOUT default and the word-width constant (32).
REQ-038 Sub-module mem_timeout_ctr SHALL provide the clear/increment counter and the expiry flag.

Verification
REQ-039 Load at ALUResult=0x10 with ack on the 2nd WAIT cycle and MemRData=0xDEADBEEF -> Stall=1 for 3 cycles, ReadData=0xDEADBEEF, RegWrite_Out=1 only in DONE.
REQ-040 Store at ALUResult=0x20 with WriteData=0x12345678 and ack in the 1st WAIT cycle -> MemWe=1, MemAddr=0x20, MemWData=0x12345678; total 3 cycles.
REQ-041 No ack with TIMEOUT=16 -> MemReq high for 16 cycles, BusErr pulses once, ReadData=0, return to IDLE.
REQ-042 Reset asserted on the 3rd WAIT cycle -> next cycle MemReq=0, Stall=0, state IDLE; a late MemAck is ignored.
REQ-043 Back-to-back load then ALU op -> the ALU op passes with Stall=0 immediately after DONE.
REQ-044 With MEM_STAGE_ALIGN_CHECK_EN defined, a load at ALUResult=0x13 -> no MemReq, AlignErr pulse, RegWrite_Out=0.
